// File: rtl/br32_pipe_pkg.sv
// Shared types and helpers for the EX/MEM pipeline buffer.
//   ex_out_t : packed EX result fields carried from EX to MEM
//   EX_OUT_W : width of ex_out_t
//   ptr_w()  : pointer width needed to address a buffer of the given depth
package br32_pipe_pkg;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] mem_addr;
        logic [31:0] cmp_res;
        logic [31:0] op3;
        logic [4:0]  rd;
        logic        w_rd;
        logic        w_cr;
        logic        link;
        logic        mem_r;
        logic        mem_w;
        logic [1:0]  mem_sz;
        logic        mem_sx;
        logic        io_r;
        logic        io_w;
        logic        mfsr;
        logic        mtsr;
        logic        mfcr;
        logic        res_in_mem;
    } ex_out_t;

    localparam int EX_OUT_W = $bits(ex_out_t);

    // A single-entry buffer needs no pointer: its one slot is implied by count.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 0 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_fifo_ram.sv
// Register-array storage for the EX/MEM pipeline buffer.
//   clk   : write clock
//   we    : write enable
//   waddr : write slot
//   wdata : entry written ({trap, pc, payload})
//   raddr : read slot
//   rdata : entry at raddr, combinational read
// Storage is deliberately not reset; validity is tracked by the controller.
module pipe_fifo_ram #(
    parameter int DEPTH = 2,
    parameter int W     = 193,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ex_mem_pipe_buf.sv
// Elastic EX->MEM pipeline buffer: a DEPTH-entry FIFO of EX results with
// valid/ready handshakes on both sides.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : EX side handshake; in_data/in_pc/in_trap is the entry
//   out_valid/out_ready : MEM side handshake; out_data/out_pc/out_trap is the head
//   flush             : synchronous discard of all entries
//   count             : occupancy
//   trap_pending      : a trap (scall/eret/udf) entry is resident
//   bubble, stall     : pipeline indications derived from the handshakes
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready of the same side, and in_ready never
// depends on out_ready, so there is no combinational path from MEM to EX.
module ex_mem_pipe_buf
    import br32_pipe_pkg::*;
#(
    parameter int DATA_W     = 160,
    parameter int DEPTH      = 2,
    parameter int TRAP_BLOCK = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic              in_trap,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic              out_trap,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output logic              trap_pending,
    output logic              bubble,
    output logic              stall
);

    localparam int PTR_W = ptr_w(DEPTH);
    // Physical pointer width; a DEPTH=1 buffer ties its pointers to zero.
    localparam int AW    = (PTR_W == 0) ? 1 : PTR_W;
    localparam int ENT_W = DATA_W + 33;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             full;
    logic [ENT_W-1:0] head;

    assign full      = (count == FULL_CNT);
    assign in_ready  = !full && !((TRAP_BLOCK != 0) && trap_pending);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign bubble    = !out_valid;
    assign stall     = in_valid && !in_ready;

    assign {out_trap, out_pc, out_data} = head;

    pipe_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata ({in_trap, in_pc, in_data}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    generate
        if (DEPTH == 1) begin : g_single
            assign wr_ptr = '0;
            assign rd_ptr = '0;
        end else begin : g_multi
            // DEPTH is a power of two, so natural overflow wraps modulo DEPTH.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + AW'(1);
                    if (pop)  rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Setting wins over clearing: a trap accepted in the same cycle that an
    // older trap leaves is now the resident one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_pending <= 1'b0;
        end else if (flush) begin
            trap_pending <= 1'b0;
        end else if (push && in_trap) begin
            trap_pending <= 1'b1;
        end else if (pop && out_trap) begin
            trap_pending <= 1'b0;
        end
    end

endmodule
